// File: rtl/gyrator_sweep_sequencer_pkg.sv
// Shared definitions for the gyrator sweep sequencer.
//   CODE_W        : width of DAC codes, frequency codes and ADC samples
//   IDX_W         : width of the result point index
//   TMR_W         : width of the settle timer
//   sweep_state_e : sequencer state encoding
package gyrator_sweep_sequencer_pkg;

  localparam int CODE_W = 16;
  localparam int IDX_W  = 8;
  localparam int TMR_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DC_SET    = 3'd1,
    ST_DC_SETTLE = 3'd2,
    ST_DC_MEAS   = 3'd3,
    ST_AC_SET    = 3'd4,
    ST_AC_SETTLE = 3'd5,
    ST_AC_MEAS   = 3'd6,
    ST_DONE      = 3'd7
  } sweep_state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle timer shared by the DC and AC settle phases.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val into the counter
//   dec       : decrement by one per cycle, holding at zero
//   load_val  : value to load
//   zero      : counter currently equals zero
module sweep_settle_timer
  import gyrator_sweep_sequencer_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gyrator_sweep_sequencer.sv
// Gyrator sweep sequencer: applies a DC bias, measures the operating point,
// then steps an AC stimulus through N_POINTS frequencies, measuring each.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle pulse, accepted only in IDLE
//   vdc_cfg, f0_cfg     : bias code and first frequency code, latched on start
//   vdc_code, ac_en,
//   freq_code           : stimulus controls
//   meas_req / meas_ack,
//   meas_data           : ADC handshake and sample
//   res_valid, res_data,
//   res_idx             : result strobe, sample, point index (0 = DC)
//   busy                : high from accepted start until DONE exits
module gyrator_sweep_sequencer
  import gyrator_sweep_sequencer_pkg::*;
#(
  parameter int                SETTLE_CYC = 16,
  parameter int                N_POINTS   = 8,
  parameter logic [CODE_W-1:0] FSTEP      = 16'd256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CODE_W-1:0] vdc_cfg,
  input  logic [CODE_W-1:0] f0_cfg,
  output logic [CODE_W-1:0] vdc_code,
  output logic              ac_en,
  output logic [CODE_W-1:0] freq_code,
  output logic              meas_req,
  input  logic              meas_ack,
  input  logic [CODE_W-1:0] meas_data,
  output logic              res_valid,
  output logic [CODE_W-1:0] res_data,
  output logic [IDX_W-1:0]  res_idx,
  output logic              busy
);

  sweep_state_e      state, state_nxt;
  logic [CODE_W-1:0] vdc_lat, f0_lat;
  logic [IDX_W-1:0]  pt_idx;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic              meas_fire, more_pts;

  assign meas_fire = meas_req && meas_ack;
  assign more_pts  = (pt_idx < IDX_W'(N_POINTS));

  sweep_settle_timer #(.W(TMR_W)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (TMR_W'(SETTLE_CYC - 1)),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_DC_SET;
      ST_DC_SET:    state_nxt = ST_DC_SETTLE;
      ST_DC_SETTLE: if (tmr_zero) state_nxt = ST_DC_MEAS;
      ST_DC_MEAS:   if (meas_ack) state_nxt = ST_AC_SET;
      ST_AC_SET:    state_nxt = ST_AC_SETTLE;
      ST_AC_SETTLE: if (tmr_zero) state_nxt = ST_AC_MEAS;
      ST_AC_MEAS:   if (meas_ack) state_nxt = more_pts ? ST_AC_SET : ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    meas_req = (state == ST_DC_MEAS) || (state == ST_AC_MEAS);
    busy     = (state != ST_IDLE);
    tmr_load = (state == ST_DC_SET) || (state == ST_AC_SET);
    tmr_dec  = (state == ST_DC_SETTLE) || (state == ST_AC_SETTLE);
  end

  // Stimulus and result registers; res_valid is a single-cycle strobe
  // following the edge on which the ADC acknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vdc_lat   <= '0;
      f0_lat    <= '0;
      pt_idx    <= '0;
      vdc_code  <= '0;
      ac_en     <= 1'b0;
      freq_code <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      res_valid <= 1'b0;
      if ((state == ST_IDLE) && start) begin
        vdc_lat <= vdc_cfg;
        f0_lat  <= f0_cfg;
        pt_idx  <= '0;
      end
      if (state == ST_DC_SET) begin
        vdc_code <= vdc_lat;
        ac_en    <= 1'b0;
      end
      if (meas_fire) begin
        res_data  <= meas_data;
        res_idx   <= pt_idx;
        res_valid <= 1'b1;
      end
      if (meas_fire && (state == ST_DC_MEAS)) begin
        pt_idx    <= IDX_W'(1);
        freq_code <= f0_lat;
        ac_en     <= 1'b1;
      end
      // ac_en drops on entry to DONE so it only spans the AC points.
      if (meas_fire && (state == ST_AC_MEAS)) begin
        if (more_pts) begin
          pt_idx    <= pt_idx + IDX_W'(1);
          freq_code <= freq_code + FSTEP;
        end else begin
          ac_en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/gyrator_sweep_sequencer.md
GYRATOR_SWEEP_SEQUENCER -- requirements
Module: gyrator_sweep_sequencer

Interface
REQ-001 Parameter SETTLE_CYC, default 16: settle wait in clk cycles after every bias or frequency change (range 1..65535).
REQ-002 Parameter N_POINTS, default 8: AC frequency points per run (range 1..255).
REQ-003 Parameter FSTEP, default 16'd256: frequency code increment between AC points.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; begins a run when idle.
REQ-007 vdc_cfg  input  16  DC bias code (Vdc source DAC) to apply for the run.
REQ-008 f0_cfg  input  16  first AC frequency code.
REQ-009 vdc_code  output  16  DC bias DAC code.
REQ-010 ac_en  output  1  enables AC stimulus source (Vac stacked on Vdc).
REQ-011 freq_code  output  16  AC stimulus frequency code.
REQ-012 meas_req  output  1  measurement request to load-voltage ADC.
REQ-013 meas_ack  input  1  ADC handshake acknowledge; meas_data valid with it.
REQ-014 meas_data  input  16  measured output-node value.
REQ-015 res_valid  output  1  one-cycle strobe; res_data/res_idx valid.
REQ-016 res_data  output  16  captured measurement.
REQ-017 res_idx  output  8  0 = DC operating point, k = AC point k (1..N_POINTS).
REQ-018 busy  output  1  high from accepted start until DONE exits.

Function
REQ-019 States IDLE, DC_SET, DC_SETTLE, DC_MEAS, AC_SET, AC_SETTLE, AC_MEAS, DONE.
REQ-020 IDLE: start=1 -> DC_SET; vdc_cfg and f0_cfg latched same edge; start ignored in every other state.
REQ-021 DC_SET (1 cycle): vdc_code<=latched bias, ac_en<=0, settle counter<=SETTLE_CYC-1 -> DC_SETTLE.
REQ-022 *_SETTLE: counter decrements per cycle; at 0 -> matching *_MEAS; dwell exactly SETTLE_CYC cycles.
REQ-023 *_MEAS: meas_req held 1 until a cycle with meas_ack=1; that edge captures meas_data into res_data, pulses res_valid next cycle, drops meas_req.
REQ-024 meas_ack while meas_req=0 SHALL be ignored; no timeout, request held indefinitely.
REQ-025 DC_MEAS done -> AC_SET with point index 1, freq_code<=latched f0, ac_en<=1.
REQ-026 AC_MEAS done: index<N_POINTS -> AC_SET with freq_code+=FSTEP (16-bit wrap, modulo 2^16), index+1; else -> DONE.
REQ-027 DONE (1 cycle): ac_en<=0, vdc_code retained, busy<=0 -> IDLE.
REQ-028 Exactly N_POINTS+1 res_valid strobes per run, res_idx strictly 0,1..N_POINTS.
REQ-029 Minimum run length with meas_ack same cycle as meas_req: (N_POINTS+1)*(SETTLE_CYC+2)+2 cycles start-to-busy-low.
REQ-030 start coincident with DONE SHALL be ignored (new run only from IDLE).

Reset
REQ-031 rst=1 at any time, mid-run included: state IDLE, vdc_code=0, ac_en=0, freq_code=0, meas_req=0, res_valid=0, res_data=0, res_idx=0, busy=0, counters 0.
REQ-032 Outputs change on rst assertion without waiting for clk; first start accepted on first clk edge after rst deasserts.

Structure
REQ-033 Shared package holds state enumeration, 16-bit code width constant, 8-bit index width constant.
REQ-034 One sub-module, sweep_settle_timer (load/decrement/zero flag), instantiated once and reused by both settle states.

Verification
REQ-035 Defaults, vdc_cfg=0x8000, f0_cfg=0x0100, ack same cycle: freq_code 0x0100..0x0800 step 0x100, 9 strobes idx 0..8, busy low after 164 cycles.
REQ-036 ack delayed 5 cycles at idx 3: meas_req stays high 6 cycles, single strobe, data captured on ack cycle only.
REQ-037 f0_cfg=0xFF00, FSTEP=0x100, N_POINTS=3: freq_code 0xFF00, 0x0000, 0x0100 (wrap).
REQ-038 rst pulse in AC_SETTLE of point 4: all outputs 0 immediately, no further strobes; subsequent start runs full sequence.
REQ-039 start pulses during busy and in DONE cycle, spurious meas_ack in settle: ignored, sequence unchanged.
REQ-040 SETTLE_CYC=1, N_POINTS=1: exactly 2 strobes idx 0,1; ac_en high only across AC_SET..AC_MEAS.
